// File: rtl/load_buffer_pkg.sv
// rtl/load_buffer_pkg.sv - shared widths, opcode codes, memory lengths and types for the load buffer
// Contents: AddressWidth/ROBWidth/IDWidth, load opcode IDs, default buffer geometry,
//           MEM_BYTE/MEM_HALF/MEM_WORD length codes, FSM state enum, FIFO entry struct,
//           and the opcode-to-length helper.
package load_buffer_pkg;

  localparam int AddressWidth = 32;
  localparam int ROBWidth     = 4;
  localparam int IDWidth      = 6;

  // Buffer geometry defaults; the top module exposes these as LBSize/LBWidth.
  localparam int DefaultLBSize  = 8;
  localparam int DefaultLBWidth = 3;

  localparam logic [IDWidth-1:0] NOP = 6'd0;
  localparam logic [IDWidth-1:0] LB  = 6'd11;
  localparam logic [IDWidth-1:0] LH  = 6'd12;
  localparam logic [IDWidth-1:0] LW  = 6'd13;
  localparam logic [IDWidth-1:0] LBU = 6'd14;
  localparam logic [IDWidth-1:0] LHU = 6'd15;

  localparam logic [1:0] MEM_BYTE = 2'd0;
  localparam logic [1:0] MEM_HALF = 2'd1;
  localparam logic [1:0] MEM_WORD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_MEM = 2'd1,
    ST_BCAST    = 2'd2
  } lb_state_t;

  typedef struct packed {
    logic [AddressWidth-1:0] addr;
    logic [ROBWidth-1:0]     dest;
    logic [IDWidth-1:0]      opcode;
  } lb_entry_t;

  // Anything that is not a byte or half load is treated as a word access.
  function automatic logic [1:0] mem_len_of(input logic [IDWidth-1:0] opcode);
    case (opcode)
      LB, LBU: mem_len_of = MEM_BYTE;
      LH, LHU: mem_len_of = MEM_HALF;
      default: mem_len_of = MEM_WORD;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// rtl/load_extend.sv - combinational sign/zero extension of right-aligned load data
// Ports: i_opcode (load opcode ID), i_data (raw 32-bit read data, right-aligned),
//        o_value (32-bit extended result).
module load_extend
  import load_buffer_pkg::*;
(
  input  logic [IDWidth-1:0] i_opcode,
  input  logic [31:0]        i_data,
  output logic [31:0]        o_value
);

  always_comb begin
    o_value = i_data;
    case (i_opcode)
      LB:      o_value = {{24{i_data[7]}}, i_data[7:0]};
      LH:      o_value = {{16{i_data[15]}}, i_data[15:0]};
      LBU:     o_value = {24'b0, i_data[7:0]};
      LHU:     o_value = {16'b0, i_data[15:0]};
      default: o_value = i_data;
    endcase
  end

endmodule

// File: rtl/load_buffer.sv
// rtl/load_buffer.sv - in-order load buffer: queues address-computed loads, issues one at a time, broadcasts results
// Ports: clk_in/rst_in/rdy_in (clock, async active-high reset, global stall);
//        addrunit_lbuffer_* (enqueue from the address unit); lbuffer_rs_full_out (back-pressure);
//        lbuffer_rob_h_out/lbuffer_rob_a_out (head tag/address to the ROB);
//        rob_lbuffer_safe_in/rob_lbuffer_rst_in (disambiguation result, misprediction flush);
//        lbuffer_memctrl_* / memctrl_lbuffer_* (read request and response);
//        lbuffer_cdb_* (result broadcast).
module load_buffer
  import load_buffer_pkg::*;
#(
  parameter int LBSize  = DefaultLBSize,
  parameter int LBWidth = DefaultLBWidth
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    addrunit_lbuffer_en_out,
  input  logic [AddressWidth-1:0] addrunit_lbuffer_a_out,
  input  logic [ROBWidth-1:0]     addrunit_lbuffer_dest_out,
  input  logic [IDWidth-1:0]      addrunit_lbuffer_opcode_out,
  output logic                    lbuffer_rs_full_out,
  output logic [ROBWidth-1:0]     lbuffer_rob_h_out,
  output logic [AddressWidth-1:0] lbuffer_rob_a_out,
  input  logic                    rob_lbuffer_safe_in,
  input  logic                    rob_lbuffer_rst_in,
  output logic                    lbuffer_memctrl_en_out,
  output logic [AddressWidth-1:0] lbuffer_memctrl_a_out,
  output logic [1:0]              lbuffer_memctrl_len_out,
  input  logic                    memctrl_lbuffer_valid_in,
  input  logic [31:0]             memctrl_lbuffer_data_in,
  output logic                    lbuffer_cdb_en_out,
  output logic [ROBWidth-1:0]     lbuffer_cdb_dest_out,
  output logic [31:0]             lbuffer_cdb_value_out
);

  localparam logic [LBWidth:0]   CntOne  = (LBWidth+1)'(1);
  localparam logic [LBWidth:0]   CntFull = (LBWidth+1)'(LBSize - 1);
  localparam logic [LBWidth:0]   CntCap  = (LBWidth+1)'(LBSize);
  localparam logic [LBWidth-1:0] PtrOne  = LBWidth'(1);

  // FIFO storage and bookkeeping
  lb_entry_t             r_entry [LBSize];
  logic [LBSize-1:0]     r_valid;
  logic [LBWidth-1:0]    r_head;
  logic [LBWidth-1:0]    r_tail;
  logic [LBWidth:0]      r_count;

  // Issue / result state
  lb_state_t             r_state;
  lb_state_t             w_next_state;
  logic                  r_mem_en;
  logic [AddressWidth-1:0] r_mem_a;
  logic [1:0]            r_mem_len;
  logic [31:0]           r_result;

  lb_entry_t             w_head;
  logic                  w_head_valid;
  logic                  w_enq;
  logic                  w_pop;
  logic                  w_issue;
  logic                  w_cdb_en;
  logic                  w_mem_done;
  logic [31:0]           w_ext_value;

  assign w_head       = r_entry[r_head];
  assign w_head_valid = r_valid[r_head];

  // A write into a completely full buffer is dropped rather than overwriting the head.
  assign w_enq      = addrunit_lbuffer_en_out && (r_count != CntCap);
  assign w_pop      = (r_state == ST_BCAST);
  assign w_mem_done = (r_state == ST_WAIT_MEM) && memctrl_lbuffer_valid_in;

  load_extend u_extend (
    .i_opcode (w_head.opcode),
    .i_data   (memctrl_lbuffer_data_in),
    .o_value  (w_ext_value)
  );

  // ---------------------------------------------------------------- FSM: state register
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state <= ST_IDLE;
    end else if (rdy_in) begin
      r_state <= w_next_state;
    end
  end

  // ---------------------------------------------------------------- FSM: next state
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:     if (w_head_valid && rob_lbuffer_safe_in) w_next_state = ST_WAIT_MEM;
      ST_WAIT_MEM: if (memctrl_lbuffer_valid_in) w_next_state = ST_BCAST;
      ST_BCAST:    w_next_state = ST_IDLE;
      default:     w_next_state = ST_IDLE;
    endcase
    // A flush abandons whatever load is in flight, including a response arriving now.
    if (rob_lbuffer_rst_in) w_next_state = ST_IDLE;
  end

  // ---------------------------------------------------------------- FSM: outputs
  always_comb begin
    w_issue  = 1'b0;
    w_cdb_en = 1'b0;
    case (r_state)
      ST_IDLE:  w_issue  = (w_next_state == ST_WAIT_MEM);
      // The broadcast is masked combinationally so a flush in this cycle never reaches the CDB.
      ST_BCAST: w_cdb_en = !rob_lbuffer_rst_in;
      default:  ;
    endcase
  end

  // ---------------------------------------------------------------- entry storage (no reset needed; guarded by r_valid)
  always_ff @(posedge clk_in) begin
    if (rdy_in && !rob_lbuffer_rst_in && w_enq) begin
      r_entry[r_tail] <= '{addr:   addrunit_lbuffer_a_out,
                           dest:   addrunit_lbuffer_dest_out,
                           opcode: addrunit_lbuffer_opcode_out};
    end
  end

  // ---------------------------------------------------------------- pointers, valid bits, request and result registers
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_valid   <= '0;
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_mem_en  <= 1'b0;
      r_mem_a   <= '0;
      r_mem_len <= '0;
      r_result  <= '0;
    end else if (rdy_in) begin
      if (rob_lbuffer_rst_in) begin
        r_valid  <= '0;
        r_head   <= '0;
        r_tail   <= '0;
        r_count  <= '0;
        r_mem_en <= 1'b0;
      end else begin
        // The request strobe is a single-cycle pulse launched on the IDLE -> WAIT_MEM edge.
        r_mem_en <= w_issue;
        if (w_issue) begin
          r_mem_a   <= w_head.addr;
          r_mem_len <= mem_len_of(w_head.opcode);
        end

        if (w_mem_done) r_result <= w_ext_value;

        // head and tail never alias here: that only happens when empty (no pop) or full (no enqueue).
        if (w_enq) begin
          r_valid[r_tail] <= 1'b1;
          r_tail          <= r_tail + PtrOne;
        end
        if (w_pop) begin
          r_valid[r_head] <= 1'b0;
          r_head          <= r_head + PtrOne;
        end

        case ({w_enq, w_pop})
          2'b10:   r_count <= r_count + CntOne;
          2'b01:   r_count <= r_count - CntOne;
          default: ;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------- outputs
  // One slot of slack: a load already dispatched by the RS still lands one cycle later.
  assign lbuffer_rs_full_out     = (r_count >= CntFull);
  assign lbuffer_rob_h_out       = w_head_valid ? w_head.dest : '0;
  assign lbuffer_rob_a_out       = w_head_valid ? w_head.addr : '0;
  assign lbuffer_memctrl_en_out  = r_mem_en;
  assign lbuffer_memctrl_a_out   = r_mem_a;
  assign lbuffer_memctrl_len_out = r_mem_len;
  assign lbuffer_cdb_en_out      = w_cdb_en;
  assign lbuffer_cdb_dest_out    = w_cdb_en ? w_head.dest : '0;
  assign lbuffer_cdb_value_out   = w_cdb_en ? r_result : '0;

endmodule

// File: tb/tb_load_buffer.sv
// tb/tb_load_buffer.sv - self-checking bench for load_buffer: vector table, corner sequences, random run vs queue model
module tb_load_buffer;
  import load_buffer_pkg::*;

  logic                    clk_in = 1'b0;
  logic                    rst_in = 1'b1;
  logic                    rdy_in = 1'b1;
  logic                    en = 1'b0;
  logic [AddressWidth-1:0] a = '0;
  logic [ROBWidth-1:0]     dest = '0;
  logic [IDWidth-1:0]      op = '0;
  logic                    full;
  logic [ROBWidth-1:0]     rob_h;
  logic [AddressWidth-1:0] rob_a;
  logic                    safe = 1'b0;
  logic                    flush = 1'b0;
  logic                    mem_en;
  logic [AddressWidth-1:0] mem_a;
  logic [1:0]              mem_len;
  logic                    mem_valid = 1'b0;
  logic [31:0]             mem_data = '0;
  logic                    cdb_en;
  logic [ROBWidth-1:0]     cdb_dest;
  logic [31:0]             cdb_value;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  load_buffer dut (
    .clk_in                      (clk_in),
    .rst_in                      (rst_in),
    .rdy_in                      (rdy_in),
    .addrunit_lbuffer_en_out     (en),
    .addrunit_lbuffer_a_out      (a),
    .addrunit_lbuffer_dest_out   (dest),
    .addrunit_lbuffer_opcode_out (op),
    .lbuffer_rs_full_out         (full),
    .lbuffer_rob_h_out           (rob_h),
    .lbuffer_rob_a_out           (rob_a),
    .rob_lbuffer_safe_in         (safe),
    .rob_lbuffer_rst_in          (flush),
    .lbuffer_memctrl_en_out      (mem_en),
    .lbuffer_memctrl_a_out       (mem_a),
    .lbuffer_memctrl_len_out     (mem_len),
    .memctrl_lbuffer_valid_in    (mem_valid),
    .memctrl_lbuffer_data_in     (mem_data),
    .lbuffer_cdb_en_out          (cdb_en),
    .lbuffer_cdb_dest_out        (cdb_dest),
    .lbuffer_cdb_value_out       (cdb_value)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=still running required=finished");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [IDWidth-1:0] op;
    logic [31:0]        data;
    int                 lat;
    logic [1:0]         exp_len;
    logic [31:0]        exp_val;
  } vec_t;

  typedef struct {
    logic [IDWidth-1:0]      op;
    logic [AddressWidth-1:0] addr;
    logic [ROBWidth-1:0]     tag;
  } ld_t;

  vec_t vecs [8];
  ld_t  q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic reset_dut();
    rst_in = 1'b1; en = 1'b0; flush = 1'b0; mem_valid = 1'b0; mem_data = '0; safe = 1'b0; rdy_in = 1'b1;
    @(posedge clk_in);
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
  endtask

  task automatic enq(input logic [IDWidth-1:0] o, input logic [31:0] ad, input logic [ROBWidth-1:0] t);
    en = 1'b1; op = o; a = ad; dest = t;
    tick();
    en = 1'b0;
  endtask

  // Memory/CDB side of one load: wait for the request, answer after lat cycles, wait for the broadcast.
  task automatic serve(input int lat, input logic [31:0] data, input bit stop_at_cdb,
                       output logic [1:0] got_len, output logic [31:0] got_addr,
                       output logic [ROBWidth-1:0] got_tag, output logic [31:0] got_val, output bit ok);
    bit seen;
    ok = 1'b0; got_len = '0; got_addr = '0; got_tag = '0; got_val = '0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (mem_en) seen = 1'b1;
      else tick();
    end
    if (!seen) return;
    got_len = mem_len; got_addr = mem_a;
    repeat (lat) tick();
    mem_valid = 1'b1; mem_data = data;
    tick();
    mem_valid = 1'b0; mem_data = '0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (cdb_en) seen = 1'b1;
      else tick();
    end
    if (!seen) return;
    got_tag = cdb_dest; got_val = cdb_value; ok = 1'b1;
    if (!stop_at_cdb) tick();
  endtask

  function automatic logic [1:0] ref_len(input logic [IDWidth-1:0] o);
    if (o == LB || o == LBU) return 2'd0;
    if (o == LH || o == LHU) return 2'd1;
    return 2'd2;
  endfunction

  function automatic logic [31:0] ref_extend(input logic [IDWidth-1:0] o, input logic [31:0] d);
    longint v;
    v = longint'(d);
    if (o == LB || o == LBU) begin
      v = v % 256;
      if (o == LB && v >= 128) v = v - 256;
    end else if (o == LH || o == LHU) begin
      v = v % 65536;
      if (o == LH && v >= 32768) v = v - 65536;
    end
    return 32'(v);
  endfunction

  task automatic random_phase(input int n_cycles, input int drain);
    logic [IDWidth-1:0] ops [5];
    int mem_wait, done, enqd, c;
    bit prev_safe, finished;
    logic [31:0] last_data;
    logic [ROBWidth-1:0] tag_ctr;
    ld_t e;
    ops = '{LB, LH, LW, LBU, LHU};
    mem_wait = -1; done = 0; enqd = 0; c = 0; prev_safe = 1'b0; finished = 1'b0;
    last_data = '0; tag_ctr = '0;
    q.delete();
    while (!finished) begin
      chk("rnd_full", full, q.size() >= DefaultLBSize - 1);
      chk("rnd_head_tag", rob_h, (q.size() != 0) ? q[0].tag : '0);
      chk("rnd_head_addr", rob_a, (q.size() != 0) ? q[0].addr : '0);
      if (q.size() == 0) begin
        chk("rnd_mem_en_empty", mem_en, 0);
        chk("rnd_cdb_en_empty", cdb_en, 0);
      end else begin
        if (mem_en) begin
          chk("rnd_issue_safe", prev_safe, 1);
          chk("rnd_mem_addr", mem_a, q[0].addr);
          chk("rnd_mem_len", mem_len, ref_len(q[0].op));
          mem_wait = $urandom_range(0, 3);
        end
      end
      if (mem_wait == 0) begin
        last_data = $urandom; mem_valid = 1'b1; mem_data = last_data; mem_wait = -1;
      end else begin
        mem_valid = 1'b0;
        if (mem_wait > 0) mem_wait--;
      end
      if (q.size() != 0 && cdb_en) begin
        chk("rnd_cdb_tag", cdb_dest, q[0].tag);
        chk("rnd_cdb_value", cdb_value, ref_extend(q[0].op, last_data));
        void'(q.pop_front());
        done++;
      end
      if (c < n_cycles && q.size() < DefaultLBSize - 1 && $urandom_range(0, 2) != 0) begin
        e.op = ops[$urandom_range(0, 4)]; e.addr = $urandom; e.tag = tag_ctr;
        tag_ctr = tag_ctr + 1'b1;
        q.push_back(e);
        en = 1'b1; op = e.op; a = e.addr; dest = e.tag;
        enqd++;
      end else begin
        en = 1'b0;
      end
      safe = ($urandom_range(0, 3) != 0);
      prev_safe = safe;
      tick();
      c++;
      if ((c >= n_cycles && q.size() == 0 && mem_wait < 0) || c >= n_cycles + drain) finished = 1'b1;
    end
    en = 1'b0; mem_valid = 1'b0;
    chk("rnd_drained", q.size(), 0);
    chk("rnd_broadcasts", done, enqd);
  endtask

  initial begin
    logic [1:0] l;
    logic [31:0] ad, v;
    logic [ROBWidth-1:0] t;
    bit ok, any;
    int start, stop, expt;

    vecs[0] = '{LB,  32'h000000F0, 2, 2'd0, 32'hFFFFFFF0};
    vecs[1] = '{LBU, 32'h000000F0, 2, 2'd0, 32'h000000F0};
    vecs[2] = '{LH,  32'h00008001, 1, 2'd1, 32'hFFFF8001};
    vecs[3] = '{LW,  32'h12345678, 0, 2'd2, 32'h12345678};
    vecs[4] = '{LHU, 32'h00008001, 3, 2'd1, 32'h00008001};
    vecs[5] = '{LB,  32'h0000007F, 1, 2'd0, 32'h0000007F};
    vecs[6] = '{LH,  32'h00007FFF, 0, 2'd1, 32'h00007FFF};
    vecs[7] = '{LB,  32'hABCDEF80, 1, 2'd0, 32'hFFFFFF80};

    // reset state, observed while reset is held
    @(posedge clk_in); #1;
    chk("rst_full", full, 0);       chk("rst_rob_h", rob_h, 0);   chk("rst_rob_a", rob_a, 0);
    chk("rst_mem_en", mem_en, 0);   chk("rst_mem_a", mem_a, 0);   chk("rst_mem_len", mem_len, 0);
    chk("rst_cdb_en", cdb_en, 0);   chk("rst_cdb_dest", cdb_dest, 0); chk("rst_cdb_value", cdb_value, 0);
    reset_dut();

    // stall: enqueue with rdy low is ignored
    rdy_in = 1'b0;
    enq(LW, 32'h500, 4'd3);
    chk("stall_no_enq", rob_h, 0);
    chk("stall_no_enq_a", rob_a, 0);
    rdy_in = 1'b1;

    // vector table: one load per row into an empty buffer
    reset_dut(); safe = 1'b1;
    for (int i = 0; i < 8; i++) begin
      start = cyc;
      enq(vecs[i].op, 32'h100 + 32'(4 * i), ROBWidth'(i + 3));
      serve(vecs[i].lat, vecs[i].data, 1'b1, l, ad, t, v, ok);
      stop = cyc;
      chk($sformatf("vec%0d_done", i), ok, 1);
      chk($sformatf("vec%0d_len", i), l, vecs[i].exp_len);
      chk($sformatf("vec%0d_addr", i), ad, 32'h100 + 32'(4 * i));
      chk($sformatf("vec%0d_tag", i), t, 32'(i + 3));
      chk($sformatf("vec%0d_value", i), v, vecs[i].exp_val);
      chk($sformatf("vec%0d_latency", i), stop - start, 3 + vecs[i].lat);
      tick();
    end

    // two queued loads leave in order
    reset_dut(); safe = 1'b1;
    enq(LH, 32'h200, 4'd1);
    enq(LW, 32'h204, 4'd2);
    serve(2, 32'h00008001, 1'b0, l, ad, t, v, ok);
    chk("pair1_done", ok, 1); chk("pair1_len", l, 1); chk("pair1_tag", t, 1); chk("pair1_value", v, 32'hFFFF8001);
    serve(1, 32'h12345678, 1'b0, l, ad, t, v, ok);
    chk("pair2_done", ok, 1); chk("pair2_len", l, 2); chk("pair2_tag", t, 2); chk("pair2_value", v, 32'h12345678);

    // head held back while the ROB reports it unsafe
    reset_dut(); safe = 1'b0;
    enq(LW, 32'h600, 4'd5);
    any = 1'b0;
    repeat (5) begin tick(); any = any | mem_en; end
    chk("safe_hold", any, 0);
    safe = 1'b1;
    tick();
    chk("safe_issue", mem_en, 1);
    serve(0, 32'h0000BEEF, 1'b0, l, ad, t, v, ok);
    chk("safe_tag", t, 5); chk("safe_addr", ad, 32'h600);

    // full threshold and pointer wrap
    reset_dut(); safe = 1'b0;
    for (int k = 0; k < 7; k++) begin
      enq(LW, 32'h1000 + 32'(4 * k), ROBWidth'(k));
      if (k == 5) chk("full_at6", full, 0);
    end
    chk("full_at7", full, 1);
    chk("full_head", rob_h, 0);
    safe = 1'b1;
    serve(0, 32'h0, 1'b0, l, ad, t, v, ok);
    chk("wrap_tag0", t, 0);
    chk("full_drop", full, 0);
    expt = 1;
    for (int k = 7; k < 12; k++) begin
      enq(LW, 32'h1000 + 32'(4 * k), ROBWidth'(k));
      serve(0, 32'(k), 1'b0, l, ad, t, v, ok);
      chk($sformatf("wrap_tag%0d", expt), t, 32'(expt));
      chk($sformatf("wrap_addr%0d", expt), ad, 32'h1000 + 32'(4 * expt));
      expt++;
    end
    while (expt < 12) begin
      serve(0, 32'(expt), 1'b0, l, ad, t, v, ok);
      chk($sformatf("wrap_tag%0d", expt), t, 32'(expt));
      chk($sformatf("wrap_addr%0d", expt), ad, 32'h1000 + 32'(4 * expt));
      expt++;
    end
    chk("wrap_empty", rob_h, 0);
    chk("wrap_full", full, 0);

    // flush during WAIT_MEM with a response and an enqueue in the same cycle
    reset_dut(); safe = 1'b1;
    enq(LW, 32'h300, 4'd4);
    any = 1'b0;
    for (int i = 0; i < 10 && !any; i++) begin
      if (mem_en) any = 1'b1; else tick();
    end
    chk("flush_issue", any, 1);
    tick();
    flush = 1'b1; mem_valid = 1'b1; mem_data = 32'h55; en = 1'b1; op = LW; a = 32'h304; dest = 4'd7;
    tick();
    flush = 1'b0; mem_valid = 1'b0; mem_data = '0; en = 1'b0;
    chk("flush_cdb", cdb_en, 0); chk("flush_head_tag", rob_h, 0);
    chk("flush_head_addr", rob_a, 0); chk("flush_full", full, 0);
    tick();
    chk("flush_cdb2", cdb_en, 0); chk("flush_mem_en", mem_en, 0);
    enq(LB, 32'h308, 4'd9);
    serve(1, 32'h80, 1'b0, l, ad, t, v, ok);
    chk("flush_next_tag", t, 9); chk("flush_next_addr", ad, 32'h308); chk("flush_next_value", v, 32'hFFFFFF80);

    // flush while broadcasting suppresses the broadcast
    enq(LW, 32'h310, 4'd2);
    serve(0, 32'h1234, 1'b1, l, ad, t, v, ok);
    chk("bflush_cdb_on", cdb_en, 1);
    flush = 1'b1;
    #1;
    chk("bflush_cdb_off", cdb_en, 0);
    tick();
    flush = 1'b0;
    chk("bflush_empty", rob_h, 0);

    // asynchronous reset in the middle of a broadcast
    enq(LW, 32'h400, 4'd6);
    serve(0, 32'hDEADBEEF, 1'b1, l, ad, t, v, ok);
    chk("areset_cdb_on", cdb_en, 1);
    #2;
    rst_in = 1'b1;
    #1;
    chk("areset_cdb_en", cdb_en, 0);  chk("areset_cdb_dest", cdb_dest, 0); chk("areset_cdb_value", cdb_value, 0);
    chk("areset_rob_h", rob_h, 0);    chk("areset_rob_a", rob_a, 0);       chk("areset_full", full, 0);
    chk("areset_mem_en", mem_en, 0);  chk("areset_mem_a", mem_a, 0);       chk("areset_mem_len", mem_len, 0);
    @(posedge clk_in); #1;
    rst_in = 1'b0;

    // randomized traffic against the queue model
    reset_dut();
    random_phase(800, 300);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
